// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the sram-like responder: size codes, LFSR constants,
// and FIFO entry geometry ({wr, data[31:0], cnt}).
package sram_like_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int cnt_w(int lat);
        return $clog2(lat + 1);
    endfunction

    function automatic int entry_w(int lat);
        return 33 + cnt_w(lat);
    endfunction

endpackage

// File: rtl/sram_like_responder_fifo.sv
// In-order response FIFO for sram_like_responder; each entry carries its own
// countdown to the cycle its data_ok may fire.
module sram_like_resp_fifo
    import sram_like_responder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    localparam int CW   = cnt_w(LAT),
    localparam int EW   = entry_w(LAT),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [EW-1:0] push_entry,
    input  logic          pop,
    output logic [EW-1:0] head_entry,
    output logic          head_ready,
    output logic [PW:0]   count
);

    logic [EW-1:0]    ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [PW:0]      cnt_q;

    assign head_entry = ent_q[rd_q];
    assign head_ready = vld_q[rd_q] && (ent_q[rd_q][CW-1:0] == '0);
    assign count      = cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && (ent_q[i][CW-1:0] != '0))
                    ent_q[i][CW-1:0] <= ent_q[i][CW-1:0] - CW'(1);
            end
            if (pop) begin
                vld_q[rd_q] <= 1'b0;
                rd_q        <= rd_q + PW'(1);
            end
            // A push never targets the popped slot: push needs a non-full FIFO
            if (push) begin
                ent_q[wr_q] <= push_entry;
                vld_q[wr_q] <= 1'b1;
                wr_q        <= wr_q + PW'(1);
            end
            cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// RAM-backed in-order responder for the sram-like request interface.
// Optional random stall injection: SRAM_LIKE_RESP_RAND_STALL_EN.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LAT    = 2,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int CW = cnt_w(LAT);
    localparam int EW = entry_w(LAT);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0]       ram_q [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              hs;
    logic              pop;
    logic              stall_req;
    logic              stall_rsp;
    logic [EW-1:0]     push_entry;
    logic [EW-1:0]     head_entry;
    logic              head_ready;
    logic [PW:0]       count;
    logic              head_wr;
    logic [31:0]       head_data;
    logic              unused_bits;

    assign idx     = addr[ADDR_W+1:2];
    // Full check uses the registered count, so a same-cycle pop does not help
    assign addr_ok = req && resetn && (count != FULL) && !stall_req;
    assign hs      = addr_ok;

    assign push_entry = {wr, (wr ? 32'h0 : ram_q[idx]), CW'(LAT - 1)};

    assign {head_wr, head_data} = head_entry[EW-1:CW];
    assign pop     = head_ready && !stall_rsp;
    assign data_ok = pop;
    assign rdata   = (pop && !head_wr) ? head_data : 32'h0;

    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0],
                           head_entry[CW-1:0]};

    always_ff @(posedge clk) begin
        if (hs && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) ram_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

`ifdef SRAM_LIKE_RESP_RAND_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign stall_req = (lfsr_q[1:0] == 2'b00);
    assign stall_rsp = (lfsr_q[3:2] == 2'b00);
`else
    assign stall_req = 1'b0;
    assign stall_rsp = 1'b0;
`endif

    sram_like_resp_fifo #(
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (hs),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .head_ready (head_ready),
        .count      (count)
    );

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed tables on LAT=2 and LAT=8
// instances plus a random run against a due-time queue model.
module tb_sram_like_responder;
    import sram_like_responder_pkg::*;

    logic        clk;
    logic        resetn;

    logic        req_a, wr_a, addr_ok_a, data_ok_a;
    logic [1:0]  size_a;
    logic [3:0]  wstrb_a;
    logic [31:0] addr_a, wdata_a, rdata_a;

    logic        req_b, wr_b, addr_ok_b, data_ok_b;
    logic [1:0]  size_b;
    logic [3:0]  wstrb_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  sz;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        eok;
        logic        edok;
        logic [31:0] erd;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mm [int];
    int          now_a   = 0;
    int          hs_cnt  = 0;
    int          dok_cnt = 0;

    sram_like_responder #(.ADDR_W(10), .LAT(2), .DEPTH(4)) u_a (
        .clk(clk), .resetn(resetn), .req(req_a), .wr(wr_a),
        .size(size_a), .wstrb(wstrb_a), .addr(addr_a), .wdata(wdata_a),
        .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a)
    );

    sram_like_responder #(.ADDR_W(10), .LAT(8), .DEPTH(4)) u_b (
        .clk(clk), .resetn(resetn), .req(req_b), .wr(wr_b),
        .size(size_b), .wstrb(wstrb_b), .addr(addr_b), .wdata(wdata_b),
        .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic strb_ok(input logic [1:0] s, input logic [3:0] st);
        case (s)
            SZ_BYTE: return $countones(st) == 1;
            SZ_HALF: return (st == 4'b0011) || (st == 4'b1100);
            SZ_WORD: return st == 4'b1111;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (resetn && wr_a && addr_ok_a)
            assert (strb_ok(size_a, wstrb_a)) else $error("wstrb/size bad on a");
        if (resetn && wr_b && addr_ok_b)
            assert (strb_ok(size_b, wstrb_b)) else $error("wstrb/size bad on b");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One model cycle on u_a: inputs already driven at the negedge
    task automatic cyc_a(output logic hs);
        logic        eok, edok;
        logic [31:0] erd, w;
        int          due, ix;
        #1;
        eok  = req_a && (q.size() < 4);
        edok = (q.size() > 0) && (q[0].due == now_a);
        erd  = edok ? q[0].d : 32'h0;
        chk("r_addr_ok", {31'h0, addr_ok_a}, {31'h0, eok});
        chk("r_data_ok", {31'h0, data_ok_a}, {31'h0, edok});
        chk("r_rdata", rdata_a, erd);
        if (data_ok_a) dok_cnt++;
        if (edok) void'(q.pop_front());
        if (eok) begin
            ix  = int'(addr_a[11:2]);
            due = now_a + 2;
            if (q.size() > 0 && q[$].due + 1 > due) due = q[$].due + 1;
            if (wr_a) begin
                w = mm.exists(ix) ? mm[ix] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (wstrb_a[b]) w[8*b +: 8] = wdata_a[8*b +: 8];
                mm[ix] = w;
                q.push_back(rsp_t'{due, 32'h0});
            end else begin
                q.push_back(rsp_t'{due, mm[ix]});
            end
            hs_cnt++;
        end
        hs = eok;
        now_a++;
        @(negedge clk);
    endtask

    initial begin
        vec_t        tbl [12];
        logic [31:0] bval [5];
        logic        h;
        logic        pend;
        int          ops, guard, tries;

        tbl[0]  = '{1'b1, 1'b1, 2'd2, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 2'd2, 4'hF, 32'h20, 32'h11223344, 1'b1, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 2'd0, 4'h4, 32'h22, 32'h00AA0000, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h20, 32'h0,        1'b1, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,  32'h0,        1'b0, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,  32'h0,        1'b0, 1'b1, 32'h11AA3344};
        tbl[7]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0};

        for (int n = 0; n < 5; n++) bval[n] = 32'hB0B0_0000 + 32'(n * 32'h111);

        resetn = 1'b0;
        req_a = 1'b1; wr_a = 1'b0; size_a = 2'd2; wstrb_a = 4'h0;
        addr_a = 32'h0; wdata_a = 32'h0;
        req_b = 1'b1; wr_b = 1'b0; size_b = 2'd2; wstrb_b = 4'h0;
        addr_b = 32'h0; wdata_b = 32'h0;

        // Reset with req held
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_addr_ok_a", {31'h0, addr_ok_a}, 32'h0);
            chk("rst_data_ok_a", {31'h0, data_ok_a}, 32'h0);
            chk("rst_rdata_a", rdata_a, 32'h0);
            chk("rst_addr_ok_b", {31'h0, addr_ok_b}, 32'h0);
        end
        @(negedge clk);
        resetn = 1'b1;
        req_b  = 1'b0;

        // Directed table on u_a (LAT=2)
        for (int i = 0; i < 12; i++) begin
            req_a   = tbl[i].req;
            wr_a    = tbl[i].wr;
            size_a  = tbl[i].sz;
            wstrb_a = tbl[i].strb;
            addr_a  = tbl[i].addr;
            wdata_a = tbl[i].wdata;
            #1;
            chk($sformatf("t%0d_addr_ok", i), {31'h0, addr_ok_a}, {31'h0, tbl[i].eok});
            chk($sformatf("t%0d_data_ok", i), {31'h0, data_ok_a}, {31'h0, tbl[i].edok});
            chk($sformatf("t%0d_rdata", i), rdata_a, tbl[i].erd);
            @(negedge clk);
        end

        // Preload u_b (LAT=8) one write at a time
        for (int n = 0; n < 5; n++) begin
            req_b = 1'b1; wr_b = 1'b1; size_b = 2'd2; wstrb_b = 4'hF;
            addr_b = 32'(n * 4); wdata_b = bval[n];
            #1;
            chk("b_pre_addr_ok", {31'h0, addr_ok_b}, 32'h1);
            @(negedge clk);
            req_b = 1'b0;
            repeat (9) @(negedge clk);
        end

        // Five back-to-back reads into a depth-4 FIFO
        wr_b = 1'b0; wstrb_b = 4'h0;
        for (int k = 0; k < 18; k++) begin
            logic        eok, edok;
            logic [31:0] erd;
            req_b  = (k <= 9);
            addr_b = 32'((k < 4 ? k : 4) * 4);
            eok    = (k < 4) || (k == 9);
            edok   = (k >= 8 && k <= 11) || (k == 17);
            erd    = edok ? bval[k == 17 ? 4 : k - 8] : 32'h0;
            #1;
            chk($sformatf("full%0d_addr_ok", k), {31'h0, addr_ok_b}, {31'h0, eok});
            chk($sformatf("full%0d_data_ok", k), {31'h0, data_ok_b}, {31'h0, edok});
            chk($sformatf("full%0d_rdata", k), rdata_b, erd);
            @(negedge clk);
        end

        // Reset with three reads outstanding
        for (int k = 0; k < 3; k++) begin
            req_b = 1'b1; addr_b = 32'(k * 4);
            #1;
            chk("rr_addr_ok", {31'h0, addr_ok_b}, 32'h1);
            @(negedge clk);
        end
        req_b = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rr_data_ok_in_rst", {31'h0, data_ok_b}, 32'h0);
        chk("rr_rdata_in_rst", rdata_b, 32'h0);
        @(negedge clk); #1;
        chk("rr_data_ok_in_rst2", {31'h0, data_ok_b}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("rr_no_stale_dok", {31'h0, data_ok_b}, 32'h0);
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            req_b = (k == 0); addr_b = 32'h8;
            #1;
            chk("rr_new_addr_ok", {31'h0, addr_ok_b}, {31'h0, (k == 0)});
            chk("rr_new_data_ok", {31'h0, data_ok_b}, {31'h0, (k == 8)});
            chk("rr_new_rdata", rdata_b, (k == 8) ? bval[2] : 32'h0);
            @(negedge clk);
        end

        // Random run on u_a against the queue model
        resetn = 1'b0;
        req_a  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        q.delete();
        now_a = 0;
        for (int i = 0; i < 16; i++) begin
            req_a = 1'b1; wr_a = 1'b1; size_a = 2'd2; wstrb_a = 4'hF;
            addr_a = 32'(i * 4); wdata_a = $urandom;
            tries = 0;
            do begin
                cyc_a(h);
                tries++;
            end while (!h && tries < 8);
            if (!h) chk("r_preload_accept", 32'h0, 32'h1);
        end

        ops = 0; guard = 0; pend = 1'b0;
        while (ops < 1000 && guard < 20000) begin
            guard++;
            if (!pend) begin
                if ($urandom_range(3) == 0) begin
                    req_a = 1'b0;
                end else begin
                    req_a   = 1'b1;
                    wr_a    = 1'($urandom_range(1));
                    addr_a  = ($urandom_range(15) << 2) | $urandom_range(3);
                    size_a  = 2'($urandom_range(2));
                    wdata_a = $urandom;
                    case (size_a)
                        2'd0:    wstrb_a = 4'(1 << $urandom_range(3));
                        2'd1:    wstrb_a = $urandom_range(1) ? 4'b1100 : 4'b0011;
                        default: wstrb_a = 4'hF;
                    endcase
                    pend = 1'b1;
                end
            end
            cyc_a(h);
            if (h) begin
                ops++;
                pend = 1'b0;
            end
        end
        chk("r_ops_done", 32'(ops), 32'd1000);
        req_a = 1'b0;
        repeat (6) cyc_a(h);
        chk("r_dok_vs_hs", 32'(dok_cnt), 32'(hs_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
